// File: rtl/pwm_capture_if.sv
// Measurement bus of pwm_capture: enable and raw PWM in, committed
// period/high counts, commit strobe and stall status out.
interface pwm_capture_if #(
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             valid;
    logic             stuck;
    logic             level;

    modport master (
        output en, pwm_in,
        input  period_cnt, high_cnt, valid, stuck, level
    );

    modport slave (
        input  en, pwm_in,
        output period_cnt, high_cnt, valid, stuck, level
    );
endinterface

// File: rtl/pwm_capture.sv
// Single-channel PWM capture: synchronises pwm_in, measures period and high
// time rise-to-rise in clk cycles, strobes each commit and flags a stalled input.
module pwm_capture #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    pwm_capture_if.slave bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO      = '0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_p_acc;
    logic [CNT_W-1:0] w_p_acc_nxt;
    logic [CNT_W-1:0] r_h_acc;
    logic [CNT_W-1:0] w_h_acc_nxt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_period_nxt;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] w_high_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_stuck;
    logic             w_stuck_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             w_rise;
    logic             w_timeout;

    assign w_rise    = r_s2 & ~r_s3;
    // A rise in the same cycle as the limit wins, so a TIMEOUT-long period still commits.
    assign w_timeout = (r_p_acc == TIMEOUT_C) & ~w_rise;

    // Synchroniser/history chain runs whenever out of reset, regardless of en.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_state  <= IDLE;
            r_p_acc  <= ZERO;
            r_h_acc  <= ZERO;
            r_period <= ZERO;
            r_high   <= ZERO;
            r_valid  <= 1'b0;
            r_stuck  <= 1'b0;
            r_level  <= 1'b0;
        end else begin
            r_s1     <= bus.pwm_in;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_state  <= w_state_nxt;
            r_p_acc  <= w_p_acc_nxt;
            r_h_acc  <= w_h_acc_nxt;
            r_period <= w_period_nxt;
            r_high   <= w_high_nxt;
            r_valid  <= w_valid_nxt;
            r_stuck  <= w_stuck_nxt;
            r_level  <= w_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_p_acc_nxt  = r_p_acc;
        w_h_acc_nxt  = r_h_acc;
        w_period_nxt = r_period;
        w_high_nxt   = r_high;
        w_valid_nxt  = 1'b0;
        w_stuck_nxt  = r_stuck;
        w_level_nxt  = r_level;

        if (!bus.en) begin
            w_state_nxt = IDLE;
            w_p_acc_nxt = ZERO;
            w_h_acc_nxt = ZERO;
            w_stuck_nxt = 1'b0;
        end else if (w_rise) begin
            // Only a rise that closes a measured period commits; the edge cycle counts as high.
            if (r_state == RUN) begin
                w_period_nxt = r_p_acc;
                w_high_nxt   = r_h_acc;
                w_valid_nxt  = 1'b1;
            end
            w_state_nxt = RUN;
            w_p_acc_nxt = ONE;
            w_h_acc_nxt = ONE;
            w_stuck_nxt = 1'b0;
        end else if (w_timeout) begin
            w_state_nxt = IDLE;
            w_p_acc_nxt = ZERO;
            w_h_acc_nxt = ZERO;
            w_stuck_nxt = 1'b1;
            w_level_nxt = r_s2;
        end else if (r_stuck) begin
            w_p_acc_nxt = ZERO;
        end else if (r_state == IDLE) begin
            w_p_acc_nxt = r_p_acc + ONE;
            w_h_acc_nxt = ZERO;
        end else begin
            w_p_acc_nxt = r_p_acc + ONE;
            w_h_acc_nxt = r_h_acc + CNT_W'(r_s2);
        end
    end

    assign bus.period_cnt = r_period;
    assign bus.high_cnt   = r_high;
    assign bus.valid      = r_valid;
    assign bus.stuck      = r_stuck;
    assign bus.level      = r_level;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Single-channel PWM measurement block: the receive side of the PWM timer outputs. It synchronises an external PWM waveform into the system clock domain. For each complete period it measures the period length and the high time in clock cycles, publishes both with a one-cycle strobe, and flags a stalled (constant-level) input. It sits between a PWM input pin and whatever logic needs the measured duty, e.g. for loop-back checking of the LED channels.

## Interface
- CNT_W, 16: width of the measurement counters and outputs.
- TIMEOUT, 16'd50000: number of clock cycles without a rising edge before `stuck` asserts. Must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W−1.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  measurement enable. When 0, the block is held idle.
- pwm_in  in  1  asynchronous PWM input.
- period_cnt  out  CNT_W  last committed period, in clk cycles (rise to rise).
- high_cnt  out  CNT_W  last committed high time, in clk cycles.
- valid  out  1  one-cycle strobe; period_cnt and high_cnt were updated this cycle.
- stuck  out  1  no rising edge seen for TIMEOUT cycles.
- level  out  1  synchronised input level latched when `stuck` set.

## Operation
- **Input path:**
  - Two-flop synchroniser s1→s2, then a history flop s3.
  - `rise` = s2 & ~s3.
  - Synchroniser flops reset to 0.
- **Accumulators:**
  - p_acc counts cycles since the last rise.
  - h_acc counts the cycles with s2=1 since the last rise.
  - Both are CNT_W bits.
- **States:** IDLE (waiting for the first rise) and RUN (at least one rise seen).
- **IDLE:**
  - p_acc increments every cycle; h_acc holds 0.
  - On `rise`: p_acc←1, h_acc←1, go to RUN. No commit.
- **RUN, no rise:**
  - p_acc←p_acc+1.
  - h_acc←h_acc+s2.
- **RUN, rise:**
  - Commit period_cnt←p_acc and high_cnt←h_acc.
  - Pulse valid next cycle.
  - Then p_acc←1, h_acc←1 (the edge cycle is counted as high). Stay in RUN.
- **Timeout:**
  - Trigger: in either state, p_acc==TIMEOUT with no rise this cycle.
  - Then stuck←1, level←s2, state←IDLE, p_acc←0.
  - While stuck=1, p_acc holds at 0. period_cnt and high_cnt hold their last values.
- **Stuck clear:** stuck clears on the next rise; that rise is treated as an IDLE rise, with no commit.
- **Simultaneous rise and p_acc==TIMEOUT:** the rise wins. The commit occurs (period_cnt may equal TIMEOUT) and stuck does not set.
- **Saturation:** none needed. TIMEOUT bounds p_acc, so no wrap-around can occur.
- **en=0:**
  - state←IDLE, p_acc←0, h_acc←0, valid←0, stuck←0.
  - period_cnt, high_cnt and level hold.
  - The synchroniser keeps running.
- **rst (overrides en):**
  - All outputs reset to 0: period_cnt, high_cnt, valid, stuck, level.
  - state=IDLE, accumulators=0, s1/s2/s3=0.
  - A reset asserted mid-period discards the partial measurement.

## Timing
- Latency: pwm_in rising, first sampled high at clk edge k, gives s2=1 after edge k+1, `rise` during cycle k+1 to k+2, and valid=1 after edge k+2. Total: 3 edges.
- valid is high for exactly one cycle per committed period.
- period_cnt and high_cnt change only in the cycle valid is high.
- Minimum measurable pulse (high or low phase) is 1 clk cycle. Shorter pulses may be lost.
- Resolution: ±1 clk cycle per edge, owing to asynchronous sampling.
- stuck asserts 1 cycle after p_acc reaches TIMEOUT.
- The first rise after reset, enable or stuck produces no valid. The first valid appears after the second rise.

## Test plan
- Ideal PWM: 250 clk high, 750 low, synchronous to clk, 3 periods → valid on the 2nd and 3rd rise (+3 edges latency), with period_cnt=1000 and high_cnt=250 each time.
- Duty extremes: high for 1 clk of a 100-clk period → high_cnt=1, period_cnt=100. Low for 1 clk of a 100-clk period → high_cnt=99, period_cnt=100.
- Stall, TIMEOUT=200: hold pwm_in=1 after one period → stuck=1 and level=1 exactly 200 cycles after the last rise, counts hold. Then resume PWM → stuck clears on the first rise, and valid returns only on the second rise.
- Boundary, TIMEOUT=200: 200-clk period → valid with period_cnt=200 and stuck stays 0. 201-clk period → stuck=1 with no valid.
- Reset and enable: assert rst mid-period → all outputs 0, and the next valid comes only after two fresh rises. Drop en for 10 cycles → valid, stuck and the accumulators clear, and the counts hold their previous values.
- Asynchronous input: pwm_in with random sub-cycle phase jitter, nominal 400/600 → every valid reports period_cnt within 999..1001 and high_cnt within 399..401.
